// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the programmable instruction memory.
// Imported by the fetch/load controller and its storage.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int MAX_DATA_W = 1024;
  localparam logic [MAX_DATA_W-1:0] NOP = '0;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/instr_mem_prog_if.sv
// Fetch handshake and byte-serial program-load port.
// master = CPU/loader side, slave = memory side.
interface instr_mem_prog_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic              if_err;

  logic              ld_start;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_done;
  logic              busy;
  logic [ADDR_W:0]   ld_count;
  logic              ld_ovf;

  modport master (
    output if_req, if_addr,
    input  if_ready, if_valid, if_instr, if_err,
    output ld_start, ld_valid, ld_byte, ld_done,
    input  busy, ld_count, ld_ovf
  );

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_valid, if_instr, if_err,
    input  ld_start, ld_valid, ld_byte, ld_done,
    output busy, ld_count, ld_ovf
  );

endinterface

// File: rtl/instr_mem_ram.sv
// Single-port synchronous RAM, registered read.
// Read register resets so the fetch output starts at zero.
module instr_mem_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_prog.sv
// Programmable instruction memory: self-clear, byte-serial load,
// one-cycle registered fetch with out-of-range error flag.
module instr_mem_prog
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input logic clk,
  input logic rst_n,
  instr_mem_prog_if.slave bus
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BPW    = bytes_per_word(DATA_W);
  localparam int CW     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [RAM_AW-1:0] CLR_LAST = RAM_AW'(DEPTH - 1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(BPW - 1);

  if ((DATA_W % 8) != 0 || DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_chk
    $error("instr_mem_prog: bad DATA_W/DEPTH/ADDR_W combination");
  end

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] clr_q, clr_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              ovf_q, ovf_d;
  logic              vld_q, err_q;

  logic              ram_we;
  logic              ram_re;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] asm_sh;
  logic              fire;
  logic              in_rng;

  assign asm_sh = (asm_q << 8) | DATA_W'(bus.ld_byte);
  assign fire   = bus.if_req && (state_q == IDLE);
  assign in_rng = {1'b0, bus.if_addr} < DEPTH_L;
  assign ram_re = fire && in_rng;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      vld_q   <= fire;
      if (fire) begin
        err_q <= !in_rng;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    ptr_d     = ptr_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    ovf_d     = ovf_q;
    ram_we    = 1'b0;
    ram_wdata = asm_sh;
    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_wdata = NOP[DATA_W-1:0];
        clr_d     = clr_q + 1'b1;
        if (clr_q == CLR_LAST) begin
          clr_d   = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (bus.ld_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          bcnt_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        // byte is taken before ld_done, so a final byte still lands
        if (bus.ld_valid) begin
          asm_d = asm_sh;
          if (bcnt_q == BYTE_LAST) begin
            bcnt_d = '0;
            if (ptr_q < DEPTH_L) begin
              ram_we = 1'b1;
              ptr_d  = ptr_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        if (bus.ld_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    ram_addr = bus.if_addr[RAM_AW-1:0];
    unique case (1'b1)
      (state_q == CLEAR): ram_addr = clr_q;
      (state_q == LOAD):  ram_addr = ptr_q[RAM_AW-1:0];
      default:            ram_addr = bus.if_addr[RAM_AW-1:0];
    endcase
  end

  instr_mem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.if_ready = (state_q == IDLE);
  assign bus.if_valid = vld_q;
  assign bus.if_instr = err_q ? NOP[DATA_W-1:0] : ram_rdata;
  assign bus.if_err   = err_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.ld_count = ptr_q;
  assign bus.ld_ovf   = ovf_q;

endmodule
